// File: rtl/lookup_sequencer.sv
// Page-table driven ROM row sequencer: fetches each row of a selected page,
// presents it until accepted, dwells a number of ticks, then steps, loops or finishes.
module lookup_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [2:0]  page,
    input  logic        loop,
    input  logic        stop,
    input  logic        tick,
    input  logic        row_ready,
    input  logic [35:0] rom_data,
    output logic [4:0]  rom_addr,
    output logic [35:0] row_data,
    output logic        row_valid,
    output logic        row_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] DWELL_N = DWELL[3:0];

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PRESENT, S_DWELL, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  base;
    logic [2:0]  last_idx;
    logic [2:0]  index;
    logic        loop_r;
    logic [3:0]  dwell_cnt;

    logic [4:0]  page_base;
    logic [2:0]  page_last;
    logic        page_ok;
    logic        dwell_hit;
    logic        abort;

    // Page table: base address and index of the final row.
    always_comb begin
        page_base = 5'd0;
        page_last = 3'd0;
        case (page)
            3'd0: begin page_base = 5'd0;  page_last = 3'd2; end
            3'd1: begin page_base = 5'd3;  page_last = 3'd2; end
            3'd2: begin page_base = 5'd6;  page_last = 3'd2; end
            3'd3: begin page_base = 5'd9;  page_last = 3'd7; end
            3'd4: begin page_base = 5'd17; page_last = 3'd7; end
            3'd5: begin page_base = 5'd25; page_last = 3'd2; end
            default: begin page_base = 5'd0; page_last = 3'd0; end
        endcase
    end

    assign page_ok   = (page < 3'd6);
    assign dwell_hit = tick && ((dwell_cnt + 4'd1) == DWELL_N);
    assign abort     = stop && (state != S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) && !stop;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start && page_ok) state_nxt = S_FETCH;
                S_FETCH:   state_nxt = S_PRESENT;
                S_PRESENT: if (row_ready) state_nxt = S_DWELL;
                S_DWELL:   if (dwell_hit) state_nxt = (row_last && !loop_r) ? S_DONE : S_FETCH;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            base      <= 5'd0;
            last_idx  <= 3'd0;
            index     <= 3'd0;
            loop_r    <= 1'b0;
            dwell_cnt <= 4'd0;
            rom_addr  <= 5'd0;
            row_data  <= 36'd0;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (abort) begin
                row_valid <= 1'b0;
                row_last  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && page_ok) begin
                            base     <= page_base;
                            last_idx <= page_last;
                            loop_r   <= loop;
                            rom_addr <= page_base;
                            index    <= 3'd0;
                        end else if (start) begin
                            err <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        row_data  <= rom_data;
                        row_last  <= (index == last_idx);
                        row_valid <= 1'b1;
                    end
                    S_PRESENT: begin
                        if (row_ready) begin
                            row_valid <= 1'b0;
                            dwell_cnt <= 4'd0;
                        end
                    end
                    S_DWELL: begin
                        if (tick) dwell_cnt <= dwell_cnt + 4'd1;
                        // Wrap back to the page base on the last row of a looping page.
                        if (dwell_hit && row_last && loop_r) begin
                            rom_addr <= base;
                            index    <= 3'd0;
                        end else if (dwell_hit && !row_last) begin
                            rom_addr <= rom_addr + 5'd1;
                            index    <= index + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lookup_sequencer.sv
// Directed bench for lookup_sequencer: expected rows are queued when a page is
// started and compared as the DUT hands each row to the consumer.
module tb_lookup_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        start, loop, stop, tick, row_ready;
    logic [2:0]  page;
    logic [35:0] rom_data;
    logic [4:0]  rom_addr;
    logic [35:0] row_data;
    logic        row_valid, row_last, busy, done, err;

    typedef struct {
        logic [4:0]  addr;
        logic [35:0] data;
        logic        last;
    } row_t;

    row_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_total = 0;
    int   extra_rows = 0;
    int   tick_cnt = 0;

    lookup_sequencer #(.DWELL(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .page(page), .loop(loop),
        .stop(stop), .tick(tick), .row_ready(row_ready), .rom_data(rom_data),
        .rom_addr(rom_addr), .row_data(row_data), .row_valid(row_valid),
        .row_last(row_last), .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [35:0] rom(input logic [4:0] a);
        return 36'h1A4666919 + 36'(a) * 36'h00101F3B5;
    endfunction

    always_comb rom_data = rom(rom_addr);

    // One-cycle tick every fourth clock.
    always @(posedge Clk) begin
        #1;
        tick = (tick_cnt % 4 == 3);
        tick_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row handed over at the coming edge: compare against the scoreboard head.
    always @(negedge Clk) begin
        if (Reset_n && row_valid && row_ready && !stop) begin
            if (q.size() == 0) begin
                extra_rows++;
            end else begin
                row_t e;
                e = q.pop_front();
                chk("row_addr", 64'(rom_addr), 64'(e.addr));
                chk("row_data", 64'(row_data), 64'(e.data));
                chk("row_last", 64'(row_last), 64'(e.last));
            end
        end
        if (done) done_total++;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_page(input int b, input int len);
        for (int i = 0; i < len; i++) begin
            row_t r;
            r.addr = 5'(b + i);
            r.data = rom(5'(b + i));
            r.last = (i == len - 1);
            q.push_back(r);
        end
    endtask

    task automatic pulse_start(input logic [2:0] p, input logic lp);
        start = 1'b1;
        page  = p;
        loop  = lp;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int dones);
        int n;
        int d0;
        n  = 0;
        d0 = done_total;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        chk("idle_in_time", 64'(busy), 64'd0);
        dones = done_total - d0;
    endtask

    initial begin
        int dn;
        int n;
        int d0;
        Reset_n   = 1'b0;
        start     = 1'b0;
        page      = 3'd0;
        loop      = 1'b0;
        stop      = 1'b0;
        row_ready = 1'b1;
        tick      = 1'b0;
        repeat (3) cyc();
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_row_data", 64'(row_data), 64'd0);
        chk("rst_row_valid", 64'(row_valid), 64'd0);
        chk("rst_row_last", 64'(row_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        Reset_n = 1'b1;
        cyc();

        // Invalid page: err for exactly one cycle, nothing else moves.
        pulse_start(3'd6, 1'b0);
        chk("inv_err", 64'(err), 64'd1);
        chk("inv_busy", 64'(busy), 64'd0);
        chk("inv_valid", 64'(row_valid), 64'd0);
        chk("inv_addr", 64'(rom_addr), 64'd0);
        page = 3'd0;
        cyc();
        chk("inv_err_off", 64'(err), 64'd0);
        chk("inv_busy2", 64'(busy), 64'd0);

        // Page 0, single pass, latency check.
        push_page(0, 3);
        pulse_start(3'd0, 1'b0);
        chk("p0_busy", 64'(busy), 64'd1);
        chk("p0_valid_early", 64'(row_valid), 64'd0);
        chk("p0_addr0", 64'(rom_addr), 64'd0);
        cyc();
        chk("p0_valid", 64'(row_valid), 64'd1);
        chk("p0_first_data", 64'(row_data), 64'h1A4666919);
        wait_idle(dn);
        chk("p0_done_cnt", 64'(dn), 64'd1);
        chk("p0_queue", 64'(q.size()), 64'd0);
        chk("p0_extra", 64'(extra_rows), 64'd0);

        // Page 5 with stop given alongside start in IDLE: start still accepted.
        push_page(25, 3);
        stop = 1'b1;
        pulse_start(3'd5, 1'b0);
        stop = 1'b0;
        chk("p5_busy", 64'(busy), 64'd1);
        chk("p5_addr", 64'(rom_addr), 64'd25);
        wait_idle(dn);
        chk("p5_done_cnt", 64'(dn), 64'd1);
        chk("p5_queue", 64'(q.size()), 64'd0);

        // Page 1 with consumer stalled; start/page/loop changes mid-page ignored.
        row_ready = 1'b0;
        push_page(3, 3);
        pulse_start(3'd1, 1'b0);
        cyc();
        chk("stall_valid", 64'(row_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin start = 1'b1; page = 3'd2; loop = 1'b1; end
            if (i == 3) start = 1'b0;
            cyc();
            chk("stall_data", 64'(row_data), 64'(rom(5'd3)));
            chk("stall_addr", 64'(rom_addr), 64'd3);
        end
        row_ready = 1'b1;
        wait_idle(dn);
        chk("stall_done_cnt", 64'(dn), 64'd1);
        chk("stall_queue", 64'(q.size()), 64'd0);
        chk("stall_extra", 64'(extra_rows), 64'd0);

        // Page 3 looping: full pass, wrap to base, stop inside second pass.
        push_page(9, 8);
        push_page(9, 2);
        q[q.size() - 1].last = 1'b0;
        d0 = done_total;
        pulse_start(3'd3, 1'b1);
        loop = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            cyc();
            n++;
        end
        chk("loop_rows_in_time", 64'(q.size()), 64'd0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_valid", 64'(row_valid), 64'd0);
        repeat (8) cyc();
        chk("loop_no_done", 64'(done_total - d0), 64'd0);
        chk("loop_extra", 64'(extra_rows), 64'd0);
        chk("stop_still_idle", 64'(busy), 64'd0);

        // Page 4 aborted by reset in DWELL, then page 1 from scratch.
        push_page(17, 8);
        d0 = done_total;
        pulse_start(3'd4, 1'b0);
        n = 0;
        while (q.size() > 6 && n < 100) begin
            cyc();
            n++;
        end
        chk("p4_progress", 64'(q.size()), 64'd6);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_rom_addr", 64'(rom_addr), 64'd0);
        chk("arst_row_data", 64'(row_data), 64'd0);
        chk("arst_row_valid", 64'(row_valid), 64'd0);
        chk("arst_row_last", 64'(row_last), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        q.delete();
        cyc();
        Reset_n = 1'b1;
        cyc();
        chk("arst_no_done", 64'(done_total - d0), 64'd0);
        push_page(3, 3);
        pulse_start(3'd1, 1'b0);
        chk("post_rst_addr", 64'(rom_addr), 64'd3);
        chk("post_rst_busy", 64'(busy), 64'd1);
        wait_idle(dn);
        chk("post_rst_done", 64'(dn), 64'd1);
        chk("post_rst_queue", 64'(q.size()), 64'd0);
        chk("post_rst_extra", 64'(extra_rows), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
